// File: rtl/hex_display_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hex_display_pkg                                              |
// | Description : Shared constants and helpers for the multiplexed 7-segment   |
// |               hex display driver: blank pattern, active-low segment table, |
// |               nibble decode function and counter-width helper.             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package hex_display_pkg;

    // All segments off (outputs are active-low).
    localparam logic [6:0] c_seg_blank = 7'h7F;

    // Active-low segment patterns, bit [0] = segment a ... bit [6] = segment g.
    // Entry n of the packed array is the pattern for hex digit n.
    localparam logic [15:0][6:0] c_seg_table = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] nibble);
        return c_seg_table[nibble];
    endfunction

    // Width of a counter that spans 0..n-1; never less than one bit so that
    // degenerate counts (one digit, one blink frame) still yield a legal vector.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_seg_decode.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hex_seg_decode                                               |
// | Description : Combinational hex nibble to active-low 7-segment decoder.    |
// |   nibble  in  4   hex digit to show                                        |
// |   seg_n   out 7   segments a..g on [0]..[6], 0 = lit                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hex_seg_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_n
);

    assign seg_n = hex_to_seg_n(nibble);

endmodule
`default_nettype wire

// File: rtl/hex_display_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hex_display_scan                                             |
// | Description : Time-multiplexed driver for an N-digit common-anode hex      |
// |               display with frame-synchronous update, leading-zero         |
// |               blanking, per-digit blink and decimal points.                |
// |   clk          in   1        system clock                                  |
// |   reset        in   1        synchronous, active-high                      |
// |   value        in   4*N      packed nibbles, [3:0] = digit 0 (rightmost)   |
// |   dp           in   N        decimal point request per digit, 1 = lit      |
// |   blink        in   N        blink enable per digit                        |
// |   load         in   1        strobe: capture value/dp/blink as pending     |
// |   enable       in   1        0 = whole display dark                        |
// |   seg_n        out  7        segments a..g, 0 = lit                        |
// |   dp_n         out  1        decimal point, 0 = lit                        |
// |   digit_sel_n  out  N        one-hot-low anode select                      |
// |   frame_start  out  1        pulse on first cycle of digit 0's slot        |
// |   busy         out  1        a load is pending, not yet displayed          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module hex_display_scan
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64,
    parameter int LZ_BLANK     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    load,
    input  logic                    enable,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_start,
    output logic                    busy
);

    localparam int SLOT_W = cnt_width(SLOT_CYCLES);
    localparam int IDX_W  = cnt_width(NUM_DIGITS);
    localparam int FRM_W  = cnt_width(BLINK_FRAMES);

    localparam logic [SLOT_W-1:0] c_slot_last = SLOT_W'(SLOT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] c_dead      = SLOT_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0]  c_idx_last  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  c_frm_last  = FRM_W'(BLINK_FRAMES - 1);

    // Scan and blink timing state
    logic [SLOT_W-1:0]       r_slot_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [FRM_W-1:0]        r_frame_cnt;
    logic                    r_blink_phase;

    // Pending regs take loads at any time; shadow regs feed the display and
    // only change on a frame boundary so a frame never mixes two values.
    logic [4*NUM_DIGITS-1:0] r_pend_value;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [NUM_DIGITS-1:0]   r_pend_blink;
    logic [4*NUM_DIGITS-1:0] r_shadow_value;
    logic [NUM_DIGITS-1:0]   r_shadow_dp;
    logic [NUM_DIGITS-1:0]   r_shadow_blink;
    logic                    r_busy;

    logic                    w_slot_wrap;
    logic                    w_boundary;
    logic [NUM_DIGITS-1:0]   w_lz_zero;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_blink;
    logic                    w_lz;
    logic                    w_blank;
    logic [6:0]              w_seg_n;
    logic [NUM_DIGITS-1:0]   w_anode_n;

    assign w_slot_wrap = (r_slot_cnt == c_slot_last);
    assign w_boundary  = w_slot_wrap && (r_idx == c_idx_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt    <= '0;
            r_idx         <= '0;
            r_frame_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_slot_cnt <= w_slot_wrap ? '0 : r_slot_cnt + 1'b1;
            if (w_slot_wrap) begin
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end
            if (w_boundary) begin
                if (r_frame_cnt == c_frm_last) begin
                    r_frame_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    // A load coinciding with the boundary wins the busy flag: the shadow takes
    // the previous pending contents while the new data waits a further frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_value   <= '0;
            r_pend_dp      <= '0;
            r_pend_blink   <= '0;
            r_shadow_value <= '0;
            r_shadow_dp    <= '0;
            r_shadow_blink <= '0;
            r_busy         <= 1'b0;
        end else begin
            if (load) begin
                r_pend_value <= value;
                r_pend_dp    <= dp;
                r_pend_blink <= blink;
            end
            if (w_boundary && r_busy) begin
                r_shadow_value <= r_pend_value;
                r_shadow_dp    <= r_pend_dp;
                r_shadow_blink <= r_pend_blink;
            end
            if (load) begin
                r_busy <= 1'b1;
            end else if (w_boundary) begin
                r_busy <= 1'b0;
            end
        end
    end

    // w_lz_zero[i]: digit i and every digit to its left are zero with no
    // decimal point, i.e. digit i is a leading zero.
    always_comb begin
        w_lz_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_lz_zero[i] = 1'b1;
            for (int j = i; j < NUM_DIGITS; j++) begin
                if ((r_shadow_value[4*j +: 4] != 4'h0) || r_shadow_dp[j]) begin
                    w_lz_zero[i] = 1'b0;
                end
            end
        end
    end

    // Per-digit selection for the digit currently being scanned.
    always_comb begin
        w_nibble = 4'h0;
        w_dp     = 1'b0;
        w_blink  = 1'b0;
        w_lz     = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nibble = r_shadow_value[4*i +: 4];
                w_dp     = r_shadow_dp[i];
                w_blink  = r_shadow_blink[i];
                w_lz     = (LZ_BLANK != 0) && (i != 0) && w_lz_zero[i];
            end
        end
    end

    assign w_blank   = w_lz || (w_blink && r_blink_phase);
    assign w_anode_n = ~(NUM_DIGITS'(1) << r_idx);

    hex_seg_decode u_decode (
        .nibble (w_nibble),
        .seg_n  (w_seg_n)
    );

    // Blanked digits keep their anode driven so the scan duty cycle is
    // identical for every digit; only the dead time releases all anodes.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_n       <= c_seg_blank;
            dp_n        <= 1'b1;
            digit_sel_n <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_boundary;
            if (!enable || (r_slot_cnt < c_dead)) begin
                seg_n       <= c_seg_blank;
                dp_n        <= 1'b1;
                digit_sel_n <= '1;
            end else begin
                digit_sel_n <= w_anode_n;
                seg_n       <= w_blank ? c_seg_blank : w_seg_n;
                dp_n        <= w_blank ? 1'b1 : ~w_dp;
            end
        end
    end

    assign busy = r_busy;

endmodule
`default_nettype wire
